// File: rtl/adder_ctrl_pkg.sv
// Shared encodings and width helpers for the adder entry sequencer.
package adder_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAP_A  = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_CAP_B  = 3'd3,
    ST_SHOW   = 3'd4
  } state_e;

  // Plain vector constants so the state register can stay a bare logic [2:0]
  // and the unused encodings 5..7 remain representable.
  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_CAP_A  = ST_CAP_A;
  localparam logic [2:0] S_WAIT_B = ST_WAIT_B;
  localparam logic [2:0] S_CAP_B  = ST_CAP_B;
  localparam logic [2:0] S_SHOW   = ST_SHOW;

  // Width of a counter that must hold 0 .. max_count-1 (at least one bit).
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability counter, and a
// one-cycle pulse when the debounced level rises.
module key_debounce
  import adder_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic k,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  // The level flips on the edge where the count would reach DEBOUNCE_CYCLES,
  // which keeps the k-to-press latency at DEBOUNCE_CYCLES+2.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          k_meta;
  logic          k_s;
  logic          db_level;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      k_meta <= 1'b0;
      k_s    <= 1'b0;
    end else begin
      k_meta <= k;
      k_s    <= k_meta;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level once stable
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      db_level <= 1'b0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (k_s == db_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt      <= '0;
        db_level <= k_s;
        press    <= k_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Operand entry sequencer for the signed 4-bit adder: debounced button steps
// through capture A, wait/capture B, and result display, with optional
// abort when B is not entered in time.
//
// state  | meaning
// IDLE   | waiting for first press, switches routed to A
// CAP_A  | one cycle: load pulse, latch sign of A
// WAIT_B | switches routed to B, timeout timer running
// CAP_B  | one cycle: latch sign of B
// SHOW   | result valid on display until next press
module adder_seq_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       k,
  input  logic       sgn,
  output logic       select,
  output logic       load,
  output logic       sa,
  output logic       sb,
  output logic       show,
  output logic       timeout,
  output logic [2:0] state
);

  localparam int            TW         = cnt_width(TIMEOUT_CYCLES);
  localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          press;
  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [TW-1:0] timer;
  logic          expire;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clock(clock),
    .reset(reset),
    .k    (k),
    .press(press)
  );

  // A press in the same cycle as the last allowed WAIT_B cycle wins
  assign expire = TIMEOUT_EN && (state_q == S_WAIT_B) && !press && (timer == TIMER_LAST);

  // Next-state decode; unused encodings fall back to IDLE
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = press ? S_CAP_A : S_IDLE;
      S_CAP_A:  state_d = S_WAIT_B;
      S_WAIT_B: begin
        if (press)       state_d = S_CAP_B;
        else if (expire) state_d = S_IDLE;
        else             state_d = S_WAIT_B;
      end
      S_CAP_B:  state_d = S_SHOW;
      S_SHOW:   state_d = press ? S_IDLE : S_SHOW;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // WAIT_B dwell timer, cleared while passing through CAP_A
  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
    end else if (state_q == S_CAP_A) begin
      timer <= '0;
    end else if ((state_q == S_WAIT_B) && TIMEOUT_EN) begin
      timer <= timer + 1'b1;
    end
  end

  // Operand sign latches, cleared on abort and when leaving SHOW
  always_ff @(posedge clock) begin
    if (reset) begin
      sa <= 1'b0;
      sb <= 1'b0;
    end else begin
      case (state_q)
        S_CAP_A:  sa <= sgn;
        S_WAIT_B: if (expire) sa <= 1'b0;
        S_CAP_B:  sb <= sgn;
        S_SHOW: begin
          if (press) begin
            sa <= 1'b0;
            sb <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign select  = (state_q == S_WAIT_B) || (state_q == S_CAP_B) || (state_q == S_SHOW);
  assign load    = (state_q == S_CAP_A);
  assign show    = (state_q == S_SHOW);
  assign timeout = expire;
  assign state   = state_q;

endmodule
